// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - requester, debug and memory signals of the shared instruction-memory port
interface imem_port_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 32
) ();
   logic          core_req;
   logic [AW-1:0] core_addr;
   logic          core_gnt;
   logic          core_rvalid;
   logic [DW-1:0] core_rdata;

   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          dbg_gnt;
   logic          dbg_rvalid;
   logic [DW-1:0] dbg_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  core_req, core_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      output core_gnt, core_rvalid, core_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output core_req, core_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      input  core_gnt, core_rvalid, core_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - debug-priority arbiter for the instruction-memory port with core anti-starvation
module imem_port_arbiter #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int MAX_DBG = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   imem_port_arbiter_if.slave   bus
);
   localparam logic [3:0] MAX_CNT = 4'(MAX_DBG);

   typedef enum logic [1:0] {NONE, CORE, DBG} owner_e;

   owner_e        rd_owner_q;
   logic [3:0]    starv_cnt_q;
   logic [3:0]    starv_cnt_d;
   logic          core_win;
   logic          dbg_win;
   logic [AW-1:0] addr_mux;
   logic [DW-1:0] wdata_mux;
   logic          core_rvalid;
   logic          dbg_rvalid;

   // Debug wins by default; the core takes the slot once debug has had MAX_DBG in a row.
   always_comb begin
      core_win = 1'b0;
      dbg_win  = 1'b0;
      if (!rst) begin
         if (bus.core_req && (!bus.dbg_req || starv_cnt_q == MAX_CNT)) begin
            core_win = 1'b1;
         end else if (bus.dbg_req) begin
            dbg_win = 1'b1;
         end
      end
   end

   always_comb begin
      starv_cnt_d = starv_cnt_q;
      if (core_win || !bus.core_req) begin
         starv_cnt_d = 4'd0;
      end else if (dbg_win && starv_cnt_q != MAX_CNT) begin
         starv_cnt_d = starv_cnt_q + 4'd1;
      end
   end

   always_comb begin
      addr_mux  = dbg_win ? bus.dbg_addr : bus.core_addr;
      wdata_mux = dbg_win ? bus.dbg_wdata : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_owner_q  <= NONE;
         starv_cnt_q <= 4'd0;
      end else begin
         starv_cnt_q <= starv_cnt_d;
         if (core_win) begin
            rd_owner_q <= CORE;
         end else if (dbg_win && !bus.dbg_we) begin
            rd_owner_q <= DBG;
         end else begin
            rd_owner_q <= NONE;
         end
      end
   end

   // Gating with rst drops the return of a read issued the cycle before reset.
   assign core_rvalid = (rd_owner_q == CORE) && !rst;
   assign dbg_rvalid  = (rd_owner_q == DBG) && !rst;

   assign bus.core_gnt    = core_win;
   assign bus.dbg_gnt     = dbg_win;
   assign bus.mem_en      = core_win | dbg_win;
   assign bus.mem_we      = dbg_win & bus.dbg_we;
   assign bus.mem_addr    = addr_mux;
   assign bus.mem_wdata   = wdata_mux;
   assign bus.core_rvalid = core_rvalid;
   assign bus.dbg_rvalid  = dbg_rvalid;
   assign bus.core_rdata  = core_rvalid ? bus.mem_rdata : '0;
   assign bus.dbg_rdata   = dbg_rvalid ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed self-checking bench for imem_port_arbiter with a sync-read memory model
module tb_imem_port_arbiter;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   logic [31:0] mem [0:63];
   logic [9:0]  cpat;

   imem_port_arbiter_if #(.DW(32), .AW(32)) bus ();

   imem_port_arbiter #(.DW(32), .AW(32), .MAX_DBG(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic cr, input logic [31:0] ca, input logic dr,
                      input logic dw, input logic [31:0] da, input logic [31:0] dd);
      bus.core_req  = cr;
      bus.core_addr = ca;
      bus.dbg_req   = dr;
      bus.dbg_we    = dw;
      bus.dbg_addr  = da;
      bus.dbg_wdata = dd;
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h00000013;
      mem[1] <= 32'h00100093;
      mem[2] <= 32'h00200113;
      mem[8] <= 32'h11111111;
      mem[9] <= 32'h22222222;
      bus.mem_rdata = 32'h0;

      // reset with both requesters active
      rst = 1'b1;
      drv(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_core_gnt", bus.core_gnt, 0);
         chk("rst_dbg_gnt", bus.dbg_gnt, 0);
         chk("rst_mem_en", bus.mem_en, 0);
         chk("rst_core_rvalid", bus.core_rvalid, 0);
         chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
         nxt();
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_dbg_gnt", bus.dbg_gnt, 1);
      chk("post_rst_core_gnt", bus.core_gnt, 0);
      nxt();
      drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("post_rst_dbg_rvalid", bus.dbg_rvalid, 1);
      chk("post_rst_dbg_rdata", bus.dbg_rdata, 32'h00000013);
      chk("post_rst_core_rvalid", bus.core_rvalid, 0);
      chk("idle_mem_en", bus.mem_en, 0);
      nxt();

      // core-only fetches, back to back
      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
         @(negedge clk);
         chk("core_gnt", bus.core_gnt, 1);
         chk("core_mem_addr", bus.mem_addr, 32'(i * 4));
         chk("core_mem_we", bus.mem_we, 0);
         chk("core_mem_wdata", bus.mem_wdata, 0);
         if (i > 0) begin
            chk("core_rvalid", bus.core_rvalid, 1);
            chk("core_rdata", bus.core_rdata, (i == 1) ? 32'h00000013 : 32'h00100093);
         end
         nxt();
      end
      drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("core_last_rvalid", bus.core_rvalid, 1);
      chk("core_last_rdata", bus.core_rdata, 32'h00200113);
      chk("core_dbg_rdata_gated", bus.dbg_rdata, 0);
      chk("core_drop_gnt", bus.core_gnt, 0);
      nxt();

      // debug write then read-back of the same word
      drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      chk("dw_dbg_gnt", bus.dbg_gnt, 1);
      chk("dw_mem_we", bus.mem_we, 1);
      chk("dw_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      chk("dw_mem_addr", bus.mem_addr, 32'h10);
      nxt();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("dw_no_rvalid", bus.dbg_rvalid, 0);
      chk("dr_mem_we", bus.mem_we, 0);
      nxt();
      drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("dr_rvalid", bus.dbg_rvalid, 1);
      chk("dr_rdata", bus.dbg_rdata, 32'hDEADBEEF);
      chk("dr_core_rvalid", bus.core_rvalid, 0);
      nxt();

      // sustained contention: core forced in every fifth slot
      cpat = 10'b10_0001_0000;
      drv(1'b1, 32'h20, 1'b1, 1'b0, 32'h24, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("cont_core_gnt", bus.core_gnt, 32'(cpat[i]));
         chk("cont_dbg_gnt", bus.dbg_gnt, 32'(!cpat[i]));
         if (i > 0) begin
            chk("cont_core_rvalid", bus.core_rvalid, 32'(cpat[i-1]));
            chk("cont_dbg_rvalid", bus.dbg_rvalid, 32'(!cpat[i-1]));
            if (cpat[i-1]) chk("cont_core_rdata", bus.core_rdata, 32'h11111111);
            else           chk("cont_dbg_rdata", bus.dbg_rdata, 32'h22222222);
         end
         nxt();
      end
      drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("cont_tail_core_rvalid", bus.core_rvalid, 1);
      chk("cont_tail_core_rdata", bus.core_rdata, 32'h11111111);
      chk("cont_tail_dbg_rvalid", bus.dbg_rvalid, 0);
      nxt();

      // reset lands on the return cycle of a debug read
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rmid_dbg_gnt", bus.dbg_gnt, 1);
      nxt();
      rst = 1'b1;
      drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rmid_dbg_rvalid", bus.dbg_rvalid, 0);
      chk("rmid_dbg_rdata", bus.dbg_rdata, 0);
      nxt();
      rst = 1'b0;
      @(negedge clk);
      chk("rmid_after_dbg_rvalid", bus.dbg_rvalid, 0);
      chk("rmid_after_core_rvalid", bus.core_rvalid, 0);
      nxt();

      // core read then debug read on consecutive cycles
      drv(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("mix_core_gnt", bus.core_gnt, 1);
      nxt();
      drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
      @(negedge clk);
      chk("mix_dbg_gnt", bus.dbg_gnt, 1);
      chk("mix_core_rvalid", bus.core_rvalid, 1);
      chk("mix_core_rdata", bus.core_rdata, 32'h00100093);
      chk("mix_dbg_rvalid_early", bus.dbg_rvalid, 0);
      nxt();
      drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      chk("mix_dbg_rvalid", bus.dbg_rvalid, 1);
      chk("mix_dbg_rdata", bus.dbg_rdata, 32'h00200113);
      chk("mix_core_rvalid_late", bus.core_rvalid, 0);
      nxt();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single instruction-memory port between two requesters: core instruction fetch and the JTAG debug module.
- The debug module uses the port for program load and readback. Core fetch is read-only.
- Sits between riscv core / jtag_top and the instruction ROM. The memory has a synchronous read: data is valid the cycle after a read is issued.
- Fixed priority goes to debug, with an anti-starvation counter that guarantees the core periodic fetch slots.

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- MAX_DBG, 4, maximum consecutive debug grants while core_req is pending before the core is forced one slot (legal range 1..15).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- core_req  in  1  core fetch request; held until core_gnt.
- core_addr  in  AW  fetch byte address.
- core_gnt  out  1  core access issued to memory this cycle.
- core_rvalid  out  1  core_rdata valid; one cycle after core_gnt.
- core_rdata  out  DW  fetched instruction.
- dbg_req  in  1  debug request; held until dbg_gnt.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  AW  debug byte address.
- dbg_wdata  in  DW  debug write data.
- dbg_gnt  out  1  debug access issued this cycle.
- dbg_rvalid  out  1  dbg_rdata valid; one cycle after a debug read grant.
- dbg_rdata  out  DW  debug read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en & ~mem_we.

Behaviour:

Arbitration (combinational, same cycle):
- At most one grant per cycle; core_gnt & dbg_gnt is never 1.
- dbg_req only: dbg wins.
- core_req only: core wins.
- Both requesting, starv_cnt < MAX_DBG: dbg wins.
- Both requesting, starv_cnt == MAX_DBG: core wins.
- Neither requesting: no grant, mem_en = 0.

Memory drive:
- mem_en = core_gnt | dbg_gnt.
- mem_we = dbg_gnt & dbg_we.
- mem_addr and mem_wdata are muxed from the winner. mem_wdata is 0 when core wins.
- mem_we is never 1 on a core grant.

Starvation counter starv_cnt (4 bits):
- Increments when dbg wins while core_req = 1.
- Clears when core wins, or when core_req = 0.
- Saturates at MAX_DBG.

Read-return FSM (state register rd_owner):
- States: NONE, CORE, DBG.
- Next state: CORE if core_gnt; DBG if dbg_gnt & ~dbg_we; otherwise NONE. This allows back-to-back transitions every cycle.
- core_rvalid = (rd_owner == CORE); dbg_rvalid = (rd_owner == DBG).
- core_rdata and dbg_rdata are both driven from mem_rdata and gated to 0 when the corresponding rvalid = 0.
- Latency: grant in cycle N, rvalid and data in cycle N+1.
- Throughput: one access per cycle.
- A debug write produces no rvalid.

Reset:
- rst = 1 forces rd_owner = NONE and starv_cnt = 0.
- Grants, mem_en and rvalids are 0 during reset regardless of req.
- A read granted in the cycle before reset asserts gets no rvalid.

Boundary cases:
- Write-then-read to the same address on consecutive cycles returns the new data (the memory provides this).
- A requester dropping req without a grant is legal; no state changes.
- MAX_DBG = 1 alternates dbg/core strictly under contention.

Test Plan:
1. Reset: assert rst for 2 cycles with core_req = dbg_req = 1 -> core_gnt = dbg_gnt = mem_en = 0, rvalids = 0; first cycle after release -> dbg_gnt = 1, starv_cnt = 1.
2. Core only: core_req = 1 for 3 cycles, addr 0x0, 0x4, 0x8; memory holds 0x00000013, 0x00100093, 0x00200113 -> core_gnt = 1 each cycle, core_rvalid cycles 2-4 with those words in order.
3. Debug write then read: dbg write 0xDEADBEEF to 0x10, then dbg read 0x10 -> mem_we = 1 in cycle 1 with no dbg_rvalid; dbg_rvalid = 1 in cycle 3 with 0xDEADBEEF.
4. Contention, MAX_DBG = 4: core_req and dbg_req held high 10 cycles -> grant pattern D,D,D,D,C,D,D,D,D,C; core_rvalid exactly one cycle after each C.
5. Reset mid-read: dbg read granted in cycle N, rst = 1 in cycle N+1 -> dbg_rvalid = 0 in cycle N+1, rd_owner = NONE afterwards.
6. Mixed: core read granted cycle N, dbg read granted cycle N+1 -> core_rvalid at N+1 and dbg_rvalid at N+2, each carrying its own address's data, never both rvalids in one cycle.
